// File: rtl/booth_stream_mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth stream multiplier.
package booth_stream_mult_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    CALC = 2'd2,
    SEND = 2'd3
  } booth_state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic dbl;
  } booth_digit_t;

  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // bits = {b[2i+1], b[2i], b[2i-1]}; 3'b111 decodes as a zero digit, never as -0.
  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    d.zero = (bits[2] == bits[1]) && (bits[1] == bits[0]);
    d.dbl  = !d.zero && (bits[1] == bits[0]);
    d.neg  = bits[2] && !d.zero;
    return d;
  endfunction

endpackage

// File: rtl/booth_stream_mult_pp.sv
// Radix-4 Booth partial-product generator: digit(bits_i) * a_i as a signed value.
module booth_r4_pp
  import booth_stream_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       bits_i,
  input  logic [WIDTH+1:0] a_i,
  output logic [WIDTH+2:0] pp_o
);

  booth_digit_t     dig;
  logic [WIDTH+2:0] mag;

  always_comb begin
    dig = booth_encode(bits_i);
    mag = dig.dbl ? {a_i, 1'b0} : {a_i[WIDTH+1], a_i};
    if (dig.zero) begin
      pp_o = '0;
    end else if (dig.neg) begin
      pp_o = -mag;
    end else begin
      pp_o = mag;
    end
  end

endmodule

// File: rtl/booth_stream_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready in/out, one digit per cycle.
// Define BOOTH_STREAM_MULT_PERF_EN to add the perf_done/perf_stall counters.
module booth_stream_mult
  import booth_stream_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [1:0]         state
`ifdef BOOTH_STREAM_MULT_PERF_EN
  ,
  output logic [31:0]        perf_done,
  output logic [31:0]        perf_stall
`endif
);

  localparam int unsigned NDIG  = booth_digits(WIDTH);
  localparam int unsigned CNT_W = $clog2(NDIG);
  localparam int unsigned XW    = WIDTH + 2;
  localparam int unsigned PPW   = WIDTH + 3;
  localparam int unsigned ACC_W = 2 * WIDTH + 4;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_stream_mult: WIDTH must be even and >= 4");
  end

  booth_state_t       state_q, state_d;
  logic [XW-1:0]      a_q, a_d;
  logic [XW:0]        mplr_q, mplr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [PPW-1:0]     pp;
  logic [ACC_W-1:0]   pp_sh;

  booth_r4_pp #(
    .WIDTH(WIDTH)
  ) u_pp (
    .bits_i(mplr_q[2:0]),
    .a_i   (a_q),
    .pp_o  (pp)
  );

  assign pp_sh = {{(ACC_W-PPW){pp[PPW-1]}}, pp} << {cnt_q, 1'b0};

  // Multiplier is held with a trailing 0 (bit -1) and shifted right two bits
  // per digit, so the current Booth triple is always mplr_q[2:0].
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mplr_d      = mplr_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    case (state_q)
      INIT: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
          mplr_d     = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
          tag_d      = in_tag;
          cnt_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_sh;
        mplr_d = mplr_q >> 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          out_data_d  = acc_d[2*WIDTH-1:0];
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      a_q         <= '0;
      mplr_q      <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mplr_q      <= mplr_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign state     = state_q;

`ifdef BOOTH_STREAM_MULT_PERF_EN
  logic [31:0] perf_done_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_done_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == SEND) begin
      if (out_ready && perf_done_q != '1) begin
        perf_done_q <= perf_done_q + 1'b1;
      end
      if (!out_ready && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
    end
  end

  assign perf_done  = perf_done_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/booth_stream_mult.md
Name: booth_stream_mult

Overview:
- Parametrised, sequential successor of the fixed-width handshake multiplier wrapper.
- Iterative radix-4 modified-Booth multiplier; processes one Booth digit per cycle.
- Selectable signed or unsigned operands per transaction; carries a tag through with each product.
- Sits between a stimulus/driver-side valid/ready interface and a monitor/consumer-side valid/ready interface.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time assertion).
- TAG_W, 4, width of the sideband tag carried with each product.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned operands.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_data  out  2*WIDTH  exact product.
- out_tag  out  TAG_W  tag of the transaction.
- state  out  2  current FSM state, for debug and coverage.

Behaviour:
- Reset (asynchronous assert, released on a clk edge):
  - in_ready=0, out_valid=0, out_data=0, out_tag=0, state=INIT.
  - All internal registers cleared.
- FSM states: INIT, IDLE, CALC, SEND.
- INIT: on the next edge, in_ready<=1, go to IDLE. in_ready therefore rises exactly one cycle after reset release.
- IDLE:
  - Accept occurs on an edge with in_valid && in_ready.
  - On accept: capture in_a, in_b, in_signed, in_tag; in_ready<=0; digit counter<=0; accumulator<=0; go to CALC.
  - in_* are ignored in every state except IDLE with in_ready=1.
- Operand extension:
  - Both operands are extended to WIDTH+2 bits: sign-extended if in_signed=1, zero-extended otherwise.
  - Number of Booth digits N = WIDTH/2+1 (N=9 for WIDTH=16).
- CALC:
  - Each cycle, take digit i from multiplier bits {2i+1, 2i, 2i-1}, with bit -1 = 0.
  - Digit values are {-2,-1,0,+1,+2}.
  - Add digit*A, shifted left by 2i, into a (2*WIDTH+4)-bit two's-complement accumulator.
  - After digit N-1: out_data<=accumulator[2*WIDTH-1:0], out_tag<=captured tag, out_valid<=1, go to SEND.
- Latency: accept on edge t0 -> out_valid high after edge t0+N.
- SEND:
  - out_data and out_tag are held stable while out_valid && !out_ready.
  - On an edge with out_ready: out_valid<=0, in_ready<=1, go to IDLE.
  - out_data keeps its last value after the handshake; it is not cleared.
- Throughput: at most one transaction per N+2 cycles. Only one transaction is ever in flight.
- Arithmetic:
  - The result is exact for all operand pairs in both modes.
  - Truncation to 2*WIDTH bits loses no information.
  - No overflow flag.
- Boundary cases:
  - in_valid asserted during CALC or SEND: no effect, no capture.
  - out_ready asserted outside SEND: no effect.
  - Reset asserted mid-CALC or mid-SEND: the transaction is dropped and all outputs return immediately to reset values.
- A valid/ready pair must not be withdrawn once offered; the bench treats a withdrawn offer as a protocol violation.

Optional Feature:
- Macro: BOOTH_STREAM_MULT_PERF_EN.
- When defined:
  - Adds output perf_done (32 bits): count of completed output handshakes.
  - Adds output perf_stall (32 bits): count of cycles spent in SEND with out_ready=0.
  - Both counters reset to 0 and saturate at all-ones.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package booth_stream_mult_pkg holds:
  - enum typedef booth_state_t {INIT, IDLE, CALC, SEND}, 2 bits.
  - Booth digit encoding typedef (sign, zero, double).
  - Function for the digit count N from WIDTH.
- One combinational sub-module, booth_r4_pp:
  - Inputs: 3 multiplier bits and the extended multiplicand.
  - Output: the signed partial product.
  - Instantiated once, reused every CALC cycle.

Test Plan:
- Post-reset: release rst -> in_ready=0 for one cycle, then 1; out_valid=0; out_data=0; state=IDLE.
- WIDTH=16 unsigned, a=16'hFFFF, b=16'hFFFF, tag=3, out_ready=1 -> out_data=32'hFFFE0001, out_tag=3, out_valid exactly 9 cycles after the accept edge.
- Signed cases: a=-32768, b=-32768 -> 32'h40000000; a=-3, b=5 -> 32'hFFFFFFF1. Same operand bits unsigned (16'hFFFD × 5) -> 32'h0004FFF1.
- Backpressure: hold out_ready=0 for 20 cycles in SEND -> out_data/out_tag stable, in_ready=0, new in_valid ignored; release -> one handshake, in_ready=1 on the following cycle.
- Reset mid-CALC: assert rst 4 cycles after accept -> outputs to reset values immediately; no stale product after recovery; the next transaction (7 × 6, unsigned) -> 42.
- With BOOTH_STREAM_MULT_PERF_EN: 3 transactions, 5 stall cycles in total -> perf_done=3, perf_stall=5. Random signed/unsigned sweep of 10k operand pairs checked against the reference model.
